ex_wb_skid: RTL and testbench
=============================

// Module: ex_wb_skid
// PURPOSE
//  Two-lane EX->WB pipeline stage with a 2-bundle skid buffer. Consumes the per-lane results
//  selected by the execute output mux (EX_AluData_0/1) plus destination tags, and presents them
//  to the writeback stage under a valid/ready handshake. Its registered ex_ready output isolates
//  the execute stage from combinational WB backpressure.
// PARAMETERS
//  DATA_W      `SIMD_DATA_WIDTH  width of each lane's result
//  RD_W        5                 destination register index width
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       synchronous reset, active low
//  EX_AluData_0  in   DATA_W  lane-0 execute result
//  EX_AluData_1  in   DATA_W  lane-1 execute result
//  ex_valid_0    in   1       lane-0 result valid
//  ex_valid_1    in   1       lane-1 result valid
//  ex_rd_0       in   RD_W    lane-0 destination register
//  ex_rd_1       in   RD_W    lane-1 destination register
//  ex_wen_0      in   1       lane-0 writes a register
//  ex_wen_1      in   1       lane-1 writes a register
//  ex_flush      in   1       discard all buffered and incoming bundles
//  ex_ready      out  1       stage can accept a bundle this cycle
//  wb_ready      in   1       writeback consumes the presented bundle
//  wb_valid_0    out  1       lane-0 output valid
//  wb_valid_1    out  1       lane-1 output valid
//  wb_data_0     out  DATA_W  lane-0 result to WB
//  wb_data_1     out  DATA_W  lane-1 result to WB
//  wb_rd_0       out  RD_W    lane-0 destination
//  wb_rd_1       out  RD_W    lane-1 destination
//  wb_wen_0      out  1       lane-0 register write enable
//  wb_wen_1      out  1       lane-1 register write enable
// BEHAVIOUR
//  - Bundle = both lanes together; bundle valid = ex_valid_0 | ex_valid_1. Lanes never split.
//  - Storage: main slot (drives wb_*) + skid slot. ex_ready = ~skid_full (pure register output).
//  - Accept = bundle valid & ex_ready & ~ex_flush. Out-fire = main_full & wb_ready.
//  - Main empty or firing: accepted bundle (or skid contents, if skid full) loads main next edge.
//    Skid always drains before new data; strict FIFO order.
//  - Main full & ~wb_ready & accept: bundle goes to skid; ex_ready drops the next cycle.
//  - Latency: 1 cycle from accept to wb_valid when empty. Throughput: 1 bundle/cycle.
//  - wb_valid_x = main_full & stored lane valid. wb_wen_x = wb_valid_x & stored wen & (rd != 0).
//    x0 writes are suppressed at capture.
//  - Invalid lane: data/rd/wen captured as zero.
//  - ex_flush: both slots empty at next edge; any bundle presented that cycle is dropped; the
//    bundle in main is not counted as consumed even if wb_ready=1. Flush beats accept.
//  - Outputs hold stable while wb_valid & ~wb_ready. No data change without out-fire.
//  - Reset (rst_n=0 at an edge): both slots empty, all wb_* = 0, ex_ready = 1.
//    Mid-operation reset drops everything, same as flush.
//  - Bundle valid with ex_ready=0: ignored. Upstream must hold the bundle. No overwrite of skid.
// STRUCTURE
//  - Define.v: SIMD_DATA_WIDTH, REG_ADDR_WIDTH, bundle field widths.
//  - Sub-module ex_wb_slot: one bundle register (valid, 2x data/rd/wen) with load and clear.
//    Instantiated twice (main, skid). Top holds the slot-select/handshake logic only.
// TESTING
//  1. Reset then single bundle v0=1, v1=0, rd0=3, data0=0xA5, wb_ready=1 -> next cycle
//     wb_valid_0=1, wb_data_0=0xA5, wb_valid_1=0; idle after.
//  2. Stream 8 bundles, wb_ready=1 -> 8 consecutive outputs in order, ex_ready held 1.
//  3. wb_ready=0 and push 2 bundles A, B -> main=A, skid=B, ex_ready=0. Third bundle C held off.
//     wb_ready=1 -> A, B, C delivered in order, no loss or duplication.
//  4. Bundle with rd0=0, wen0=1 -> wb_valid_0=1, wb_wen_0=0.
//  5. Both slots full + ex_flush with new bundle D -> next cycle wb_valid_*=0, ex_ready=1,
//     D never appears.
//  6. Assert rst_n=0 mid-stall with skid full -> all wb_* = 0, ex_ready=1.
//     Resume -> normal operation.

Source files
------------

// File: rtl/ex_wb_skid_pkg.sv
// Shared widths, the main-slot source select and the lane write-enable rule
// for the EX->WB skid stage.
package ex_wb_skid_pkg;

  localparam int SIMD_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH  = 5;

  // Where the main slot takes its next bundle from.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_EX   = 2'd1,
    SRC_SKID = 2'd2
  } main_src_e;

  // A lane only writes when it is valid and does not target x0.
  function automatic logic lane_wen(input logic valid, input logic wen,
                                    input logic rd_nonzero);
    return valid & wen & rd_nonzero;
  endfunction

endpackage

// File: rtl/ex_wb_slot.sv
// One two-lane bundle register. Invalid lanes and x0 writes are scrubbed at
// capture, so the stored fields can drive writeback directly.
module ex_wb_slot
  import ex_wb_skid_pkg::*;
#(
  parameter int DATA_W = SIMD_DATA_WIDTH,
  parameter int RD_W   = REG_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              valid_0_i,
  input  logic              valid_1_i,
  input  logic [DATA_W-1:0] data_0_i,
  input  logic [DATA_W-1:0] data_1_i,
  input  logic [RD_W-1:0]   rd_0_i,
  input  logic [RD_W-1:0]   rd_1_i,
  input  logic              wen_0_i,
  input  logic              wen_1_i,
  output logic              full_o,
  output logic              valid_0_o,
  output logic              valid_1_o,
  output logic [DATA_W-1:0] data_0_o,
  output logic [DATA_W-1:0] data_1_o,
  output logic [RD_W-1:0]   rd_0_o,
  output logic [RD_W-1:0]   rd_1_o,
  output logic              wen_0_o,
  output logic              wen_1_o
);

  logic              valid_0_q, valid_1_q;
  logic [DATA_W-1:0] data_0_q, data_1_q;
  logic [RD_W-1:0]   rd_0_q, rd_1_q;
  logic              wen_0_q, wen_1_q;

  // Bundle register: clear (reset/flush/drain) beats load.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      valid_0_q <= 1'b0;
      valid_1_q <= 1'b0;
      data_0_q  <= '0;
      data_1_q  <= '0;
      rd_0_q    <= '0;
      rd_1_q    <= '0;
      wen_0_q   <= 1'b0;
      wen_1_q   <= 1'b0;
    end else if (load_i) begin
      valid_0_q <= valid_0_i;
      valid_1_q <= valid_1_i;
      data_0_q  <= valid_0_i ? data_0_i : '0;
      data_1_q  <= valid_1_i ? data_1_i : '0;
      rd_0_q    <= valid_0_i ? rd_0_i : '0;
      rd_1_q    <= valid_1_i ? rd_1_i : '0;
      wen_0_q   <= lane_wen(valid_0_i, wen_0_i, |rd_0_i);
      wen_1_q   <= lane_wen(valid_1_i, wen_1_i, |rd_1_i);
    end
  end

  // A stored bundle always has at least one valid lane.
  assign full_o    = valid_0_q | valid_1_q;
  assign valid_0_o = valid_0_q;
  assign valid_1_o = valid_1_q;
  assign data_0_o  = data_0_q;
  assign data_1_o  = data_1_q;
  assign rd_0_o    = rd_0_q;
  assign rd_1_o    = rd_1_q;
  assign wen_0_o   = wen_0_q;
  assign wen_1_o   = wen_1_q;

endmodule

// File: rtl/ex_wb_skid.sv
// Two-lane EX->WB stage: a main slot presenting to writeback plus a skid slot
// absorbing one bundle of backpressure. ex_ready is a flop so WB stall never
// reaches EX combinationally.
module ex_wb_skid
  import ex_wb_skid_pkg::*;
#(
  parameter int DATA_W = SIMD_DATA_WIDTH,
  parameter int RD_W   = REG_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] EX_AluData_0,
  input  logic [DATA_W-1:0] EX_AluData_1,
  input  logic              ex_valid_0,
  input  logic              ex_valid_1,
  input  logic [RD_W-1:0]   ex_rd_0,
  input  logic [RD_W-1:0]   ex_rd_1,
  input  logic              ex_wen_0,
  input  logic              ex_wen_1,
  input  logic              ex_flush,
  output logic              ex_ready,
  input  logic              wb_ready,
  output logic              wb_valid_0,
  output logic              wb_valid_1,
  output logic [DATA_W-1:0] wb_data_0,
  output logic [DATA_W-1:0] wb_data_1,
  output logic [RD_W-1:0]   wb_rd_0,
  output logic [RD_W-1:0]   wb_rd_1,
  output logic              wb_wen_0,
  output logic              wb_wen_1
);

  logic              ex_ready_q, ex_ready_d;
  logic              main_full, skid_full;
  logic              accept, fire, main_free;
  logic              main_load, main_clr, skid_load, skid_clr, skid_full_d;
  main_src_e         main_src;

  logic              skid_valid_0, skid_valid_1;
  logic [DATA_W-1:0] skid_data_0, skid_data_1;
  logic [RD_W-1:0]   skid_rd_0, skid_rd_1;
  logic              skid_wen_0, skid_wen_1;

  logic              mux_valid_0, mux_valid_1;
  logic [DATA_W-1:0] mux_data_0, mux_data_1;
  logic [RD_W-1:0]   mux_rd_0, mux_rd_1;
  logic              mux_wen_0, mux_wen_1;

  assign accept    = (ex_valid_0 | ex_valid_1) & ex_ready_q & ~ex_flush;
  assign fire      = main_full & wb_ready;
  assign main_free = ~main_full | fire;

  // Slot steering: the skid drains into main before any new bundle, keeping
  // FIFO order; a blocked main diverts the accepted bundle into the skid.
  // NOTE: every signal gets a default up front so no path infers a latch.
  always_comb begin
    main_src  = SRC_NONE;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (main_free) begin
      if (skid_full) begin
        main_src = SRC_SKID;
        skid_clr = 1'b1;
      end else if (accept) begin
        main_src = SRC_EX;
      end
    end else if (accept) begin
      skid_load = 1'b1;
    end
    if (ex_flush) skid_clr = 1'b1;
  end

  assign main_load   = (main_src != SRC_NONE);
  assign main_clr    = ex_flush | (fire & ~main_load);
  assign skid_full_d = skid_clr ? 1'b0 : (skid_load | skid_full);
  assign ex_ready_d  = ~skid_full_d;

  // Main-slot input select: skid contents or the incoming EX bundle.
  always_comb begin
    mux_valid_0 = ex_valid_0;
    mux_valid_1 = ex_valid_1;
    mux_data_0  = EX_AluData_0;
    mux_data_1  = EX_AluData_1;
    mux_rd_0    = ex_rd_0;
    mux_rd_1    = ex_rd_1;
    mux_wen_0   = ex_wen_0;
    mux_wen_1   = ex_wen_1;
    if (main_src == SRC_SKID) begin
      mux_valid_0 = skid_valid_0;
      mux_valid_1 = skid_valid_1;
      mux_data_0  = skid_data_0;
      mux_data_1  = skid_data_1;
      mux_rd_0    = skid_rd_0;
      mux_rd_1    = skid_rd_1;
      mux_wen_0   = skid_wen_0;
      mux_wen_1   = skid_wen_1;
    end
  end

  // Registered ready mirrors next-cycle skid occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) ex_ready_q <= 1'b1;
    else        ex_ready_q <= ex_ready_d;
  end

  assign ex_ready = ex_ready_q;

  ex_wb_slot #(.DATA_W(DATA_W), .RD_W(RD_W)) u_main (
    .clk(clk), .rst_n(rst_n), .clr_i(main_clr), .load_i(main_load),
    .valid_0_i(mux_valid_0), .valid_1_i(mux_valid_1),
    .data_0_i(mux_data_0), .data_1_i(mux_data_1),
    .rd_0_i(mux_rd_0), .rd_1_i(mux_rd_1),
    .wen_0_i(mux_wen_0), .wen_1_i(mux_wen_1),
    .full_o(main_full),
    .valid_0_o(wb_valid_0), .valid_1_o(wb_valid_1),
    .data_0_o(wb_data_0), .data_1_o(wb_data_1),
    .rd_0_o(wb_rd_0), .rd_1_o(wb_rd_1),
    .wen_0_o(wb_wen_0), .wen_1_o(wb_wen_1)
  );

  ex_wb_slot #(.DATA_W(DATA_W), .RD_W(RD_W)) u_skid (
    .clk(clk), .rst_n(rst_n), .clr_i(skid_clr), .load_i(skid_load),
    .valid_0_i(ex_valid_0), .valid_1_i(ex_valid_1),
    .data_0_i(EX_AluData_0), .data_1_i(EX_AluData_1),
    .rd_0_i(ex_rd_0), .rd_1_i(ex_rd_1),
    .wen_0_i(ex_wen_0), .wen_1_i(ex_wen_1),
    .full_o(skid_full),
    .valid_0_o(skid_valid_0), .valid_1_o(skid_valid_1),
    .data_0_o(skid_data_0), .data_1_o(skid_data_1),
    .rd_0_o(skid_rd_0), .rd_1_o(skid_rd_1),
    .wen_0_o(skid_wen_0), .wen_1_o(skid_wen_1)
  );

endmodule

// File: tb/tb_ex_wb_skid.sv
// Self-checking bench for ex_wb_skid: directed table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_ex_wb_skid;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] d0, d1;
  logic          v0, v1, w0, w1, flush, wbr;
  logic [RW-1:0] rd0, rd1;
  logic          ex_ready;
  logic          wb_valid_0, wb_valid_1, wb_wen_0, wb_wen_1;
  logic [DW-1:0] wb_data_0, wb_data_1;
  logic [RW-1:0] wb_rd_0, wb_rd_1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_wb_skid #(.DATA_W(DW), .RD_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .EX_AluData_0(d0), .EX_AluData_1(d1),
    .ex_valid_0(v0), .ex_valid_1(v1),
    .ex_rd_0(rd0), .ex_rd_1(rd1),
    .ex_wen_0(w0), .ex_wen_1(w1),
    .ex_flush(flush), .ex_ready(ex_ready), .wb_ready(wbr),
    .wb_valid_0(wb_valid_0), .wb_valid_1(wb_valid_1),
    .wb_data_0(wb_data_0), .wb_data_1(wb_data_1),
    .wb_rd_0(wb_rd_0), .wb_rd_1(wb_rd_1),
    .wb_wen_0(wb_wen_0), .wb_wen_1(wb_wen_1)
  );

  // ---------------- reference model: a queue of at most two bundles ----------
  typedef struct packed {
    logic          v0, v1;
    logic [DW-1:0] d0, d1;
    logic [RW-1:0] rd0, rd1;
    logic          w0, w1;
  } bundle_t;

  bundle_t mq[$];
  bit      m_ready = 1'b1;

  function automatic bundle_t scrub(bundle_t b);
    bundle_t r = '0;
    r.v0 = b.v0;
    r.v1 = b.v1;
    if (b.v0) begin r.d0 = b.d0; r.rd0 = b.rd0; r.w0 = b.w0 && (b.rd0 != 0); end
    if (b.v1) begin r.d1 = b.d1; r.rd1 = b.rd1; r.w1 = b.w1 && (b.rd1 != 0); end
    return r;
  endfunction

  task automatic model_edge();
    bundle_t in_b;
    bit acc;
    in_b = '{v0: v0, v1: v1, d0: d0, d1: d1, rd0: rd0, rd1: rd1, w0: w0, w1: w1};
    if (!rst_n) begin
      mq.delete();
    end else begin
      acc = (v0 || v1) && m_ready && !flush;
      if (flush) mq.delete();
      else begin
        if (mq.size() > 0 && wbr) void'(mq.pop_front());
        if (acc) mq.push_back(scrub(in_b));
      end
    end
    m_ready = (mq.size() < 2);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    bundle_t e = (mq.size() > 0) ? mq[0] : '0;
    check({tag, ".ready"}, 64'(ex_ready),   64'(m_ready));
    check({tag, ".v0"},    64'(wb_valid_0), 64'(e.v0));
    check({tag, ".v1"},    64'(wb_valid_1), 64'(e.v1));
    check({tag, ".d0"},    64'(wb_data_0),  64'(e.d0));
    check({tag, ".d1"},    64'(wb_data_1),  64'(e.d1));
    check({tag, ".rd0"},   64'(wb_rd_0),    64'(e.rd0));
    check({tag, ".rd1"},   64'(wb_rd_1),    64'(e.rd1));
    check({tag, ".wen0"},  64'(wb_wen_0),   64'(e.w0));
    check({tag, ".wen1"},  64'(wb_wen_1),   64'(e.w1));
  endtask

  task automatic drive(input logic a_v0, input logic a_v1,
                       input logic [DW-1:0] a_d0, input logic [DW-1:0] a_d1,
                       input logic [RW-1:0] a_rd0, input logic [RW-1:0] a_rd1,
                       input logic a_w0, input logic a_w1,
                       input logic a_fl, input logic a_wbr);
    v0 = a_v0; v1 = a_v1; d0 = a_d0; d1 = a_d1;
    rd0 = a_rd0; rd1 = a_rd1; w0 = a_w0; w1 = a_w1;
    flush = a_fl; wbr = a_wbr;
  endtask

  task automatic idle(input logic a_wbr);
    drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, a_wbr);
  endtask

  task automatic push0(input logic [DW-1:0] data, input logic a_wbr);
    drive(1'b1, 1'b0, data, '0, 5'd1, '0, 1'b1, 1'b0, 1'b0, a_wbr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(1'b1);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          v0, v1;
    logic [DW-1:0] d0, d1;
    logic [RW-1:0] rd0, rd1;
    logic          w0, w1, wbr;
    logic          ev0, ev1;
    logic [DW-1:0] ed0, ed1;
    logic [RW-1:0] erd0, erd1;
    logic          ew0, ew1, erdy;
  } vec_t;

  vec_t vecs[5];

  initial begin
    //            inputs: v0 v1 d0 d1 rd0 rd1 w0 w1 wbr | expected: v0 v1 d0 d1 rd0 rd1 w0 w1 rdy
    vecs[0] = '{1, 0, 32'hA5, 32'h0, 5'd3, 5'd0, 1, 0, 1,   1, 0, 32'hA5, 32'h0, 5'd3, 5'd0, 1, 0, 1};
    vecs[1] = '{0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 0, 1,    0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 0, 1};
    vecs[2] = '{1, 1, 32'h1234, 32'hBEEF, 5'd0, 5'd7, 1, 1, 1,
                1, 1, 32'h1234, 32'hBEEF, 5'd0, 5'd7, 0, 1, 1};
    vecs[3] = '{0, 1, 32'hFF, 32'h55, 5'd9, 5'd4, 1, 0, 1,  0, 1, 32'h0, 32'h55, 5'd0, 5'd4, 0, 0, 1};
    vecs[4] = '{0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 0, 1,    0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 0, 1};

    rst_n = 1'b0;
    idle(1'b1);
    do_reset();

    // Reset state
    check("reset.ready", 64'(ex_ready), 64'd1);
    check("reset.v0",    64'(wb_valid_0), 64'd0);
    check("reset.v1",    64'(wb_valid_1), 64'd0);
    check("reset.d0",    64'(wb_data_0), 64'd0);

    // Table: single bundle, idle, x0 write suppression, invalid-lane scrub
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].v0, vecs[i].v1, vecs[i].d0, vecs[i].d1, vecs[i].rd0, vecs[i].rd1,
            vecs[i].w0, vecs[i].w1, 1'b0, vecs[i].wbr);
      tick();
      check($sformatf("vec%0d.v0", i),   64'(wb_valid_0), 64'(vecs[i].ev0));
      check($sformatf("vec%0d.v1", i),   64'(wb_valid_1), 64'(vecs[i].ev1));
      check($sformatf("vec%0d.d0", i),   64'(wb_data_0),  64'(vecs[i].ed0));
      check($sformatf("vec%0d.d1", i),   64'(wb_data_1),  64'(vecs[i].ed1));
      check($sformatf("vec%0d.rd0", i),  64'(wb_rd_0),    64'(vecs[i].erd0));
      check($sformatf("vec%0d.rd1", i),  64'(wb_rd_1),    64'(vecs[i].erd1));
      check($sformatf("vec%0d.wen0", i), 64'(wb_wen_0),   64'(vecs[i].ew0));
      check($sformatf("vec%0d.wen1", i), 64'(wb_wen_1),   64'(vecs[i].ew1));
      check($sformatf("vec%0d.rdy", i),  64'(ex_ready),   64'(vecs[i].erdy));
    end

    // Stream of 8 bundles at full rate
    for (int i = 0; i < 8; i++) begin
      push0(32'(100 + i), 1'b1);
      tick();
      check($sformatf("stream%0d.v0", i), 64'(wb_valid_0), 64'd1);
      check($sformatf("stream%0d.d0", i), 64'(wb_data_0), 64'(100 + i));
      check($sformatf("stream%0d.rdy", i), 64'(ex_ready), 64'd1);
    end
    idle(1'b1);
    tick();
    check("stream.drained", 64'(wb_valid_0), 64'd0);

    // Backpressure: A to main, B to skid, C held off, then drain in order
    push0(32'hA, 1'b0); tick();
    check("bp.A.d0",  64'(wb_data_0), 64'hA);
    check("bp.A.rdy", 64'(ex_ready), 64'd1);
    push0(32'hB, 1'b0); tick();
    check("bp.B.rdy", 64'(ex_ready), 64'd0);
    check("bp.B.hold", 64'(wb_data_0), 64'hA);
    push0(32'hC, 1'b0); tick();
    check("bp.C.rdy", 64'(ex_ready), 64'd0);
    check("bp.C.hold", 64'(wb_data_0), 64'hA);
    push0(32'hC, 1'b1); tick();
    check("bp.out1", 64'(wb_data_0), 64'hB);
    check("bp.rdy1", 64'(ex_ready), 64'd1);
    push0(32'hC, 1'b1); tick();
    check("bp.out2", 64'(wb_data_0), 64'hC);
    check("bp.v2",   64'(wb_valid_0), 64'd1);
    idle(1'b1); tick();
    check("bp.empty", 64'(wb_valid_0), 64'd0);
    check_model("bp.model");

    // Flush with both slots full and a new bundle D presented
    push0(32'h1A, 1'b0); tick();
    push0(32'h1B, 1'b0); tick();
    check("fl.full", 64'(ex_ready), 64'd0);
    drive(1'b1, 1'b1, 32'hD, 32'hD, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    check("fl.v0",  64'(wb_valid_0), 64'd0);
    check("fl.v1",  64'(wb_valid_1), 64'd0);
    check("fl.rdy", 64'(ex_ready), 64'd1);
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fl.noD%0d", i), 64'(wb_valid_0 | wb_valid_1), 64'd0);
    end

    // Reset mid-stall with skid full, then resume
    push0(32'h2A, 1'b0); tick();
    push0(32'h2B, 1'b0); tick();
    check("rs.full", 64'(ex_ready), 64'd0);
    rst_n = 1'b0; idle(1'b0); tick();
    check("rs.rdy", 64'(ex_ready), 64'd1);
    check("rs.v0",  64'(wb_valid_0), 64'd0);
    check("rs.d0",  64'(wb_data_0), 64'd0);
    check("rs.rd0", 64'(wb_rd_0), 64'd0);
    check("rs.wen0", 64'(wb_wen_0), 64'd0);
    rst_n = 1'b1;
    push0(32'hE, 1'b1); tick();
    check("rs.resume.d0", 64'(wb_data_0), 64'hE);
    check("rs.resume.v0", 64'(wb_valid_0), 64'd1);
    idle(1'b1); tick();

    // Random traffic against the reference model
    for (int c = 0; c < 500; c++) begin
      rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
      if ($urandom_range(0, 3) == 0) rd0 = '0;
      tick();
      check_model($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
